read_interface: RTL

READ_INTERFACE -- requirements
Module: read_interface

---
 rtl/read_interface.sv | 104 ++++++++++
 1 files changed

// File: rtl/read_interface.sv
`default_nettype none
// ============================================================================
//  Module   : read_interface
//  Purpose  : Host-side receive path for a UART. Buffers received bytes in a
//             4-entry circular FIFO, presents the head byte and a status word
//             to the host, and raises a registered interrupt while data or an
//             overrun is pending. Host reads complete on the falling edge of
//             the read strobes.
//  Revision : 1.0  initial release
// ============================================================================
module read_interface #(
  parameter int DEPTH = 4
) (
  input  logic       i_Clock,
  input  logic       i_reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       data_re,
  input  logic       stat_re,
  output logic [7:0] data_out,
  output logic [7:0] status_out,
  output logic       rx_irq
);

  localparam logic [2:0] c_full_count = 3'(DEPTH);

  logic [7:0] r_mem [0:3];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_overrun;
  logic       r_underflow;
  logic       r_re_d;
  logic       r_st_d;
  logic       r_irq;

  logic       w_pop;
  logic       w_clr;
  logic       w_empty;
  logic       w_full;
  logic       w_do_push;
  logic       w_do_pop;
  logic       w_ovr_set;
  logic       w_und_set;
  logic [2:0] w_count_nxt;
  logic       w_ovr_nxt;
  logic       w_und_nxt;

  // Strobe falling edges complete a host access; flag decisions for this cycle.
  always_comb begin
    w_pop       = r_re_d & ~data_re;
    w_clr       = r_st_d & ~stat_re;
    w_empty     = (r_count == 3'd0);
    w_full      = (r_count == c_full_count);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    w_do_push   = rx_valid & (~w_full | w_pop);
    // A pop on an empty FIFO is ignored even if a push lands in that cycle.
    w_do_pop    = w_pop & ~w_empty;
    w_ovr_set   = rx_valid & w_full & ~w_pop;
    w_und_set   = w_pop & w_empty;
    w_count_nxt = r_count + {2'b00, w_do_push} - {2'b00, w_do_pop};
    // A set event wins over a coincident clear.
    w_ovr_nxt   = w_ovr_set | (r_overrun & ~w_clr);
    w_und_nxt   = w_und_set | (r_underflow & ~w_clr);
  end

  // Control state: pointers, occupancy, sticky flags, strobe history, irq.
  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr    <= 2'd0;
      r_rd_ptr    <= 2'd0;
      r_count     <= 3'd0;
      r_overrun   <= 1'b0;
      r_underflow <= 1'b0;
      r_re_d      <= 1'b0;
      r_st_d      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_re_d      <= data_re;
      r_st_d      <= stat_re;
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      r_count     <= w_count_nxt;
      r_overrun   <= w_ovr_nxt;
      r_underflow <= w_und_nxt;
      r_irq       <= (w_count_nxt != 3'd0) | w_ovr_nxt;
    end
  end

  // Byte storage; contents are don't-care after reset since count gates reads.
  always_ff @(posedge i_Clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= rx_data;
  end

  // Host-visible head byte and status word.
  always_comb begin
    data_out   = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    status_out = {1'b0, r_count, r_underflow, r_overrun, w_full, ~w_empty};
  end

  assign rx_irq = r_irq;

endmodule
`default_nettype wire
